// File: rtl/spi_result_tx.sv
// -----------------------------------------------------------------------------
// spi_result_tx
//   Serial transmitter for the multi-lane SPI-style link. One parallel word is
//   taken per frame over a start/ready handshake and sent MSB first on every
//   lane in lockstep. spi_en, spi_clk and spi_data are all generated here and
//   are registered, so a receiver sampling through synchronizers on its own
//   system clock sees data stable for a full half-period on each side of every
//   spi_clk rising edge.
//
// Ports:
//   clk      in   system clock
//   nrst     in   asynchronous active-low reset
//   start    in   request to send data_in (only honoured while ready=1)
//   data_in  in   DATA_WIDTH*DATA_DEPTH payload, lane i in bits
//                 [DATA_DEPTH*(i+1)-1 : DATA_DEPTH*i]
//   ready    out  idle and able to accept start
//   done     out  one-cycle pulse when a frame completes
//   spi_en   out  frame enable, high for the whole frame
//   spi_clk  out  serial clock, idle low
//   spi_data out  bit i = current bit of lane i
// -----------------------------------------------------------------------------
module spi_result_tx #(
    parameter int DATA_WIDTH  = 2,
    parameter int DATA_DEPTH  = 24,
    parameter int HALF_PERIOD = 4
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic                             start,
    input  logic [DATA_WIDTH*DATA_DEPTH-1:0] data_in,
    output logic                             ready,
    output logic                             done,
    output logic                             spi_en,
    output logic                             spi_clk,
    output logic [DATA_WIDTH-1:0]            spi_data
);

    localparam int HP_W  = $clog2(HALF_PERIOD);
    localparam int BIT_W = $clog2(DATA_DEPTH + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEAD  = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_TRAIL = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]            r_state;
    logic [HP_W-1:0]       r_hp_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic                  r_done;
    logic                  r_spi_en;
    logic                  r_spi_clk;
    logic [DATA_DEPTH-1:0] r_shift [DATA_WIDTH];

    logic                  w_hp_last;
    logic [DATA_WIDTH-1:0] w_spi_data;

    assign w_hp_last = (r_hp_cnt == HP_W'(HALF_PERIOD - 1));

    // The lane shift registers double as the spi_data output register: the
    // MSB of each lane is the bit on the wire. Clearing them at the end of
    // TRAIL drives spi_data back to 0 between frames.
    always_comb begin
        w_spi_data = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            w_spi_data[i] = r_shift[i][DATA_DEPTH-1];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= S_IDLE;
            r_hp_cnt  <= '0;
            r_bit_cnt <= '0;
            r_done    <= 1'b0;
            r_spi_en  <= 1'b0;
            r_spi_clk <= 1'b0;
            for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
                r_shift[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
                            r_shift[i] <= data_in[DATA_DEPTH*i +: DATA_DEPTH];
                        end
                        r_spi_en  <= 1'b1;
                        r_bit_cnt <= '0;
                        r_hp_cnt  <= '0;
                        r_state   <= S_LEAD;
                    end
                end
                S_LEAD, S_LOW: begin
                    if (w_hp_last) begin
                        r_hp_cnt  <= '0;
                        r_spi_clk <= 1'b1;
                        r_state   <= S_HIGH;
                    end else begin
                        r_hp_cnt <= r_hp_cnt + HP_W'(1);
                    end
                end
                S_HIGH: begin
                    if (w_hp_last) begin
                        r_hp_cnt  <= '0;
                        r_spi_clk <= 1'b0;
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        if (r_bit_cnt == BIT_W'(DATA_DEPTH - 1)) begin
                            // Last bit: hold data through TRAIL.
                            r_state <= S_TRAIL;
                        end else begin
                            // Next bit appears on the same edge spi_clk falls.
                            for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
                                r_shift[i] <= r_shift[i] << 1;
                            end
                            r_state <= S_LOW;
                        end
                    end else begin
                        r_hp_cnt <= r_hp_cnt + HP_W'(1);
                    end
                end
                S_TRAIL: begin
                    if (w_hp_last) begin
                        r_hp_cnt <= '0;
                        r_spi_en <= 1'b0;
                        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
                            r_shift[i] <= '0;
                        end
                        r_state <= S_GAP;
                    end else begin
                        r_hp_cnt <= r_hp_cnt + HP_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_hp_last) begin
                        r_hp_cnt <= '0;
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_hp_cnt <= r_hp_cnt + HP_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready    = (r_state == S_IDLE);
    assign done     = r_done;
    assign spi_en   = r_spi_en;
    assign spi_clk  = r_spi_clk;
    assign spi_data = w_spi_data;

endmodule

// File: tb/tb_spi_result_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_result_tx
//   Self-checking bench for spi_result_tx. A waveform monitor samples both DUT
//   instances on the falling system-clock edge, reconstructs each lane from the
//   values seen at spi_clk rises, measures frame timing and flags any data
//   movement that is not on a spi_clk fall or a spi_en edge. Completed frames
//   are compared with values computed from the payload and the frame-timing
//   formulas.
// -----------------------------------------------------------------------------
module tb_spi_result_tx;

    localparam int DW  = 2;
    localparam int DD  = 24;
    localparam int HP  = 4;
    localparam int DD2 = 8;
    localparam int HP2 = 6;
    localparam int WAIT_LIMIT = 4000;

    logic            clk  = 1'b0;
    logic            nrst = 1'b0;
    logic            start = 1'b0;
    logic [DW*DD-1:0] data_in = '0;
    logic            ready, done, spi_en, spi_clk;
    logic [DW-1:0]   spi_data;

    logic             start2 = 1'b0;
    logic [DW*DD2-1:0] data2 = '0;
    logic             ready2, done2, en2, sclk2;
    logic [DW-1:0]    sd2;

    always #5 clk = ~clk;

    spi_result_tx u_dut (
        .clk(clk), .nrst(nrst), .start(start), .data_in(data_in),
        .ready(ready), .done(done), .spi_en(spi_en), .spi_clk(spi_clk),
        .spi_data(spi_data)
    );

    spi_result_tx #(.DATA_WIDTH(DW), .DATA_DEPTH(DD2), .HALF_PERIOD(HP2)) u_dut2 (
        .clk(clk), .nrst(nrst), .start(start2), .data_in(data2),
        .ready(ready2), .done(done2), .spi_en(en2), .spi_clk(sclk2),
        .spi_data(sd2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int          rises;
        int          en_len;
        int          en_rise;
        int          done_cyc;
        int          last_chg;
        int          last_rise;
        int          first_off;
        int          terr;
        int          en_low_run;
        int          gap_before;
        logic [63:0] l0;
        logic [63:0] l1;
        logic        p_en;
        logic        p_clk;
        logic        p_dn;
        logic [1:0]  p_d;
        bit          fin;
    } mon_t;

    function automatic mon_t mon_step(mon_t s, logic en, logic sc, logic [1:0] d,
                                      logic dn, int hp, int c);
        mon_t n = s;
        n.fin = 1'b0;
        if (en && !s.p_en) begin
            n.en_rise    = c;
            n.rises      = 0;
            n.en_len     = 0;
            n.terr       = 0;
            n.l0         = '0;
            n.l1         = '0;
            n.last_chg   = c;
            n.gap_before = s.en_low_run;
            n.first_off  = -1;
        end
        if (en) n.en_len = n.en_len + 1;
        n.en_low_run = en ? 0 : s.en_low_run + 1;
        if (d !== s.p_d) begin
            n.last_chg = c;
            if (!(s.p_clk && !sc) && (en == s.p_en)) n.terr = n.terr + 1;
        end
        if (sc && !en) n.terr = n.terr + 1;
        if (sc && !s.p_clk) begin
            if (c - n.last_chg < hp) n.terr = n.terr + 1;
            if (n.rises == 0) n.first_off = c - n.en_rise;
            n.rises     = n.rises + 1;
            n.l0        = {n.l0[62:0], d[0]};
            n.l1        = {n.l1[62:0], d[1]};
            n.last_rise = c;
        end
        if (!sc && s.p_clk && (c - s.last_rise != hp)) n.terr = n.terr + 1;
        if (dn) begin
            if (s.p_dn) n.terr = n.terr + 1;
            n.done_cyc = c;
            n.fin      = 1'b1;
        end
        n.p_en  = en;
        n.p_clk = sc;
        n.p_dn  = dn;
        n.p_d   = d;
        return n;
    endfunction

    mon_t m1 = '0;
    mon_t m2 = '0;
    mon_t q1[$];
    mon_t q2[$];
    int   ndone1 = 0;

    always @(negedge clk) begin
        m1 = mon_step(m1, spi_en, spi_clk, spi_data, done, HP, cyc);
        if (m1.fin) begin
            q1.push_back(m1);
            ndone1 = ndone1 + 1;
        end
        m2 = mon_step(m2, en2, sclk2, sd2, done2, HP2, cyc);
        if (m2.fin) q2.push_back(m2);
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected values come straight from the payload and the frame-timing rules:
    // lane i is payload bits [dd*(i+1)-1 : dd*i], dd rises, en high hp*(2dd+1),
    // first rise hp after en, start edge to done edge hp*(2dd+2)+1.
    task automatic check_frame(input string tag, input mon_t r, input logic [63:0] payload,
                               input int dd, input int hp);
        logic [63:0] mask;
        mask = (64'd1 << dd) - 64'd1;
        chk({tag, ".lane0"}, r.l0, payload & mask);
        chk({tag, ".lane1"}, r.l1, (payload >> dd) & mask);
        chk({tag, ".rises"}, 64'(r.rises), 64'(dd));
        chk({tag, ".en_len"}, 64'(r.en_len), 64'(hp * (2*dd + 1)));
        chk({tag, ".first_rise"}, 64'(r.first_off), 64'(hp));
        // done is sampled by the clocked logic one edge after the cycle it is seen in.
        chk({tag, ".latency"}, 64'(r.done_cyc - r.en_rise + 1), 64'(hp * (2*dd + 2) + 1));
        chk({tag, ".timing_errs"}, 64'(r.terr), 64'd0);
    endtask

    task automatic get_frame(input int sel, input string tag, output mon_t r, output bit ok);
        int n = 0;
        ok = 1'b0;
        r  = '0;
        while (n < WAIT_LIMIT) begin
            if (sel == 1 && q1.size() > 0) begin r = q1.pop_front(); ok = 1'b1; break; end
            if (sel == 2 && q2.size() > 0) begin r = q2.pop_front(); ok = 1'b1; break; end
            @(posedge clk);
            n++;
        end
        chk({tag, ".frame_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_en(input logic lvl, input string tag);
        int n = 0;
        while (spi_en !== lvl && n < WAIT_LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= WAIT_LIMIT) chk({tag, ".wait_en"}, 64'(spi_en), 64'(lvl));
    endtask

    task automatic send1(input logic [47:0] v);
        @(posedge clk); #1;
        start = 1'b1; data_in = v;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run1(input string tag, input logic [47:0] v);
        mon_t r; bit ok;
        send1(v);
        get_frame(1, tag, r, ok);
        if (ok) check_frame(tag, r, 64'(v), DD, HP);
    endtask

    initial begin
        mon_t        r;
        bit          ok;
        logic [63:0] rnd;
        logic [47:0] v0;
        int          d0;
        int          n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", 64'(ready), 64'd1);
        chk("rst.en", 64'(spi_en), 64'd0);
        chk("rst.clk", 64'(spi_clk), 64'd0);
        chk("rst.data", 64'(spi_data), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        @(negedge clk);
        nrst = 1'b1;

        // Directed frame
        run1("fixed", 48'hA5A5A5_3C3C3C);

        // Random payloads
        for (int k = 0; k < 3; k++) begin
            rnd = {$urandom, $urandom};
            run1($sformatf("rand%0d", k), rnd[47:0]);
        end

        // Busy handshake: second start while sending is ignored
        d0 = ndone1;
        send1(48'hFFFFFF_000000);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; data_in = 48'h123456_654321;
        @(posedge clk); #1;
        start = 1'b0;
        get_frame(1, "busy", r, ok);
        if (ok) check_frame("busy", r, 64'h0000_FFFFFF_000000, DD, HP);
        repeat (40) @(posedge clk);
        #1;
        chk("busy.extra_frames", 64'(q1.size()), 64'd0);
        chk("busy.done_count", 64'(ndone1 - d0), 64'd1);
        chk("busy.idle_en", 64'(spi_en), 64'd0);
        chk("busy.ready", 64'(ready), 64'd1);

        // Back-to-back with start held high
        rnd = {$urandom, $urandom};
        v0  = rnd[47:0];
        @(posedge clk); #1;
        start = 1'b1; data_in = v0;
        wait_en(1'b1, "b2b.f1");
        data_in = 48'h000001_800000;
        wait_en(1'b0, "b2b.f1end");
        wait_en(1'b1, "b2b.f2");
        start = 1'b0;
        get_frame(1, "b2b.f1", r, ok);
        if (ok) check_frame("b2b.f1", r, 64'(v0), DD, HP);
        get_frame(1, "b2b.f2", r, ok);
        if (ok) begin
            check_frame("b2b.f2", r, 64'h0000_000001_800000, DD, HP);
            // GAP cycles plus the done cycle in which the new start is taken.
            chk("b2b.gap", 64'(r.gap_before), 64'(HP + 1));
        end
        repeat (20) @(posedge clk);
        #1;
        chk("b2b.no_third", 64'(q1.size()), 64'd0);

        // Reset mid-frame after the 5th spi_clk rise
        rnd = {$urandom, $urandom};
        send1(rnd[47:0]);
        n = 0;
        while (m1.rises < 5 && n < WAIT_LIMIT) begin
            @(posedge clk);
            n++;
        end
        chk("mid.reached5", 64'(m1.rises >= 5), 64'd1);
        #2;
        nrst = 1'b0;
        #1;
        chk("mid.en", 64'(spi_en), 64'd0);
        chk("mid.clk", 64'(spi_clk), 64'd0);
        chk("mid.data", 64'(spi_data), 64'd0);
        chk("mid.ready", 64'(ready), 64'd1);
        chk("mid.done", 64'(done), 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (5) @(posedge clk);
        chk("mid.no_partial", 64'(q1.size()), 64'd0);
        rnd = {$urandom, $urandom};
        run1("after_rst", rnd[47:0]);

        // Parameter sweep instance
        @(posedge clk); #1;
        start2 = 1'b1; data2 = 16'hC35A;
        @(posedge clk); #1;
        start2 = 1'b0;
        get_frame(2, "sweep", r, ok);
        if (ok) check_frame("sweep", r, 64'h0000_0000_0000_C35A, DD2, HP2);
        rnd = {$urandom, $urandom};
        @(posedge clk); #1;
        start2 = 1'b1; data2 = rnd[15:0];
        @(posedge clk); #1;
        start2 = 1'b0;
        get_frame(2, "sweep_rand", r, ok);
        if (ok) check_frame("sweep_rand", r, 64'(rnd[15:0]), DD2, HP2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
